tt_sweep_checker: RTL and testbench

- Parametrised, synthesizable, self-checking exhaustive truth-table sweeper for an N-input single-output combinational function.
- Drives every input vector 0..2^N_IN-1 in ascending order and holds each vector for HOLD cycles.
- Samples the DUT output at the end of each hold window and compares it against a parameterised expected truth table.
- Reports error count, first failing vector and pass/fail; sits beside any fN_implK block on the lab board or in simulation.

---
 rtl/tt_sweep_checker.sv | 96 +++++++++
 tb/tb_tt_sweep_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: walks every input vector of an N_IN-input DUT,
// samples its output at the end of each hold window and tallies mismatches.
module tt_sweep_checker #(
    parameter int                   N_IN   = 4,
    parameter int                   HOLD   = 50,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 16'h8E3A
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_f,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            aborted,
    output logic [N_IN:0]   err_count,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_idx
);
    localparam int             HW        = $clog2(HOLD);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic          mismatch;

    assign mismatch = (dut_f != EXPECT[vec]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            vec             <= '0;
            hold_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            aborted         <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= RUN;
                        vec             <= '0;
                        hold_cnt        <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        aborted         <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Abort skips any comparison due on this edge.
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        pass    <= 1'b0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        if (mismatch) begin
                            err_count <= err_count + 1'b1;
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_idx   <= vec;
                            end
                        end
                        // pass must include the verdict of the final sample taken now.
                        if (vec == LAST_VEC) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !mismatch && (err_count == '0);
                        end else begin
                            vec      <= vec + 1'b1;
                            hold_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed and randomized sweeps of tt_sweep_checker against a table-driven reference.
module tb_tt_sweep_checker;
    localparam int          H   = 50;
    localparam logic [15:0] EXP = 16'h8E3A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, dut_f;
    logic [15:0] tab;
    logic [3:0]  vec, first_err_idx;
    logic        busy, done, pass, aborted, first_err_valid;
    logic [4:0]  err_count;

    assign dut_f = tab[vec];

    tt_sweep_checker #(.N_IN(4), .HOLD(H), .EXPECT(EXP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_f(dut_f),
        .vec(vec), .busy(busy), .done(done), .pass(pass), .aborted(aborted),
        .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_idx(first_err_idx)
    );

    logic       start2, use_xor, dut_f2;
    logic [3:0] tab2;
    logic [1:0] vec2, first_err_idx2;
    logic       busy2, done2, pass2, aborted2, first_err_valid2;
    logic [2:0] err_count2;

    assign dut_f2 = use_xor ? (vec2[1] ^ vec2[0]) : tab2[vec2];

    tt_sweep_checker #(.N_IN(2), .HOLD(2), .EXPECT(4'b0110)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .dut_f(dut_f2),
        .vec(vec2), .busy(busy2), .done(done2), .pass(pass2), .aborted(aborted2),
        .err_count(err_count2), .first_err_valid(first_err_valid2),
        .first_err_idx(first_err_idx2)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: count table disagreements over the first nv vectors.
    function automatic void model(input logic [15:0] t, input logic [15:0] e, input int nv,
                                  output int errs, output int first);
        errs  = 0;
        first = -1;
        for (int i = 0; i < nv; i++) begin
            if (t[i] !== e[i]) begin
                errs++;
                if (first < 0) first = i;
            end
        end
    endfunction

    // One full sweep of the default instance; abort_at/start_at are cycles after the
    // accepting start edge (0 = never).
    task automatic sweep(input string tag, input logic [15:0] t, input int abort_at,
                         input int start_at);
        int  cyc, nv, errs, first, probe, exp_cyc;
        bit  seen, ab;
        logic [15:0] e;
        e     = EXP;
        tab   = t;
        start = 1'b1;
        step();
        start = 1'b0;
        probe = $urandom_range(1, 790);
        cyc   = 0;
        seen  = 0;
        for (int c = 1; c <= 1000 && !seen; c++) begin
            abort = (c == abort_at);
            start = (c == start_at);
            step();
            abort = 1'b0;
            start = 1'b0;
            if (c == probe && !done) begin
                chk({tag, "/probe_vec"}, vec, c / H);
                chk({tag, "/probe_busy"}, busy, 1);
            end
            if (done) begin
                seen = 1;
                cyc  = c;
            end
        end
        ab      = (abort_at > 0 && abort_at < 800);
        nv      = ab ? (abort_at - 1) / H : 16;
        exp_cyc = ab ? abort_at : 800;
        model(t, e, nv, errs, first);
        $display("sweep %s: table=%h abort_at=%0d done_cycle=%0d err_count=%0d pass=%0b",
                 tag, t, abort_at, cyc, err_count, pass);
        chk({tag, "/done_cycle"}, cyc, exp_cyc);
        chk({tag, "/err_count"}, err_count, errs);
        chk({tag, "/first_valid"}, first_err_valid, (first >= 0));
        chk({tag, "/first_idx"}, first_err_idx, (first >= 0) ? first : 0);
        chk({tag, "/pass"}, pass, (!ab && errs == 0));
        chk({tag, "/aborted"}, aborted, ab);
        chk({tag, "/vec"}, vec, ab ? nv : 15);
        chk({tag, "/busy"}, busy, 0);
    endtask

    task automatic sweep2(input string tag, input bit xr, input logic [3:0] t);
        int  cyc, errs, fi;
        bit  seen;
        logic [15:0] f, e;
        for (int i = 0; i < 4; i++) f[i] = xr ? ((i >> 1) ^ i) & 1 : t[i];
        f[15:4] = '0;
        e       = 16'h0006;
        use_xor = xr;
        tab2    = t;
        start2  = 1'b1;
        step();
        start2 = 1'b0;
        cyc    = 0;
        seen   = 0;
        for (int c = 1; c <= 50 && !seen; c++) begin
            step();
            if (done2) begin
                seen = 1;
                cyc  = c;
            end
        end
        model(f, e, 4, errs, fi);
        $display("sweep2 %s: xor=%0b table=%b done_cycle=%0d err_count=%0d pass=%0b",
                 tag, xr, t, cyc, err_count2, pass2);
        chk({tag, "/done_cycle"}, cyc, 8);
        chk({tag, "/err_count"}, err_count2, errs);
        chk({tag, "/first_idx"}, first_err_idx2, (fi >= 0) ? fi : 0);
        chk({tag, "/pass"}, pass2, (errs == 0));
        chk({tag, "/vec"}, vec2, 3);
        chk({tag, "/aborted"}, aborted2, 0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "/vec"}, vec, 0);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/done"}, done, 0);
        chk({tag, "/pass"}, pass, 0);
        chk({tag, "/aborted"}, aborted, 0);
        chk({tag, "/err_count"}, err_count, 0);
        chk({tag, "/first_valid"}, first_err_valid, 0);
        chk({tag, "/first_idx"}, first_err_idx, 0);
    endtask

    initial begin
        logic [15:0] rt;
        int          ra;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        start2  = 1'b0;
        use_xor = 1'b1;
        tab     = '0;
        tab2    = '0;
        step();
        step();
        chk_cleared("reset");
        chk("reset/done2", done2, 0);
        rst_n = 1'b1;
        step();
        chk_cleared("idle");

        sweep("golden", EXP, 0, 0);
        sweep("stuck0", 16'h0000, 0, 0);
        sweep("stuck1", 16'hFFFF, 0, 0);
        sweep("abort275", 16'h0000, 275, 0);
        sweep("start_ignored", 16'hFFFF, 0, 100);

        // Reset for one edge partway through a failing sweep.
        tab   = 16'h0000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 400; c++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        $display("reset mid-sweep at cycle 400");
        chk_cleared("midreset");
        step();
        chk("midreset/stay_idle_busy", busy, 0);
        sweep("after_reset", EXP, 0, 0);

        for (int k = 0; k < 6; k++) begin
            rt = 16'($urandom);
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 799)) : 0;
            sweep($sformatf("rand%0d", k), rt, ra, 0);
        end

        sweep2("xor", 1'b1, 4'b0000);
        sweep2("xor_restart", 1'b1, 4'b0000);
        for (int k = 0; k < 3; k++) sweep2($sformatf("rand2_%0d", k), 1'b0, 4'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
